// File: rtl/pipelined_barrel_shifter.sv
// Pipelined multi-mode barrel shifter: LSL/LSR/ASR/ROL/ROR/PASS over log2(WIDTH)
// registered stages, with carry-out and zero flags and a valid/ready stall.
module pipelined_barrel_shifter #(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SHW-1:0]   in_shamt,
    input  logic [2:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_carry,
    output logic             out_zero
);

    localparam logic [2:0] MODE_LSL = 3'b000;
    localparam logic [2:0] MODE_LSR = 3'b001;
    localparam logic [2:0] MODE_ASR = 3'b010;
    localparam logic [2:0] MODE_ROL = 3'b011;
    localparam logic [2:0] MODE_ROR = 3'b100;

    // The whole pipe moves as one; it only freezes when an unread result blocks the output.
    logic advance_s;
    logic zero_r;

    assign advance_s = !out_valid || out_ready;
    assign in_ready  = advance_s;

    for (genvar k = 0; k < SHW; k++) begin : g_stage
        localparam int AMT = 1 << k;

        logic [WIDTH-1:0] d_s;
        logic [WIDTH-1:0] q_s;
        logic [SHW-1:0]   sh_s;
        logic [2:0]       m_s;
        logic             c_s;
        logic             cq_s;
        logic             v_s;

        logic [WIDTH-1:0] data_r;
        logic             carry_r;
        logic             valid_r;

        if (k == 0) begin : g_src
            assign d_s  = in_data;
            assign sh_s = in_shamt;
            assign m_s  = in_mode;
            assign c_s  = 1'b0;
            assign v_s  = in_valid;
        end else begin : g_src
            assign d_s  = g_stage[k-1].data_r;
            assign sh_s = g_stage[k-1].g_ctl.shamt_r;
            assign m_s  = g_stage[k-1].g_ctl.mode_r;
            assign c_s  = g_stage[k-1].carry_r;
            assign v_s  = g_stage[k-1].valid_r;
        end

        // Conditional 2^k step; carry keeps the most recent bit pushed off the end.
        always_comb begin
            q_s  = d_s;
            cq_s = c_s;
            if (sh_s[k]) begin
                case (m_s)
                    MODE_LSL: begin
                        q_s  = d_s << AMT;
                        cq_s = d_s[WIDTH-AMT];
                    end
                    MODE_LSR: begin
                        q_s  = d_s >> AMT;
                        cq_s = d_s[AMT-1];
                    end
                    MODE_ASR: begin
                        q_s  = $signed(d_s) >>> AMT;
                        cq_s = d_s[AMT-1];
                    end
                    MODE_ROL: begin
                        q_s  = (d_s << AMT) | (d_s >> (WIDTH - AMT));
                        cq_s = 1'b0;
                    end
                    MODE_ROR: begin
                        q_s  = (d_s >> AMT) | (d_s << (WIDTH - AMT));
                        cq_s = 1'b0;
                    end
                    default: begin
                        q_s  = d_s;
                        cq_s = 1'b0;
                    end
                endcase
            end else begin
                q_s  = d_s;
                cq_s = c_s;
            end
        end

        // Stage data/carry/valid register.
        always_ff @(posedge clk) begin
            if (rst) begin
                data_r  <= {WIDTH{1'b0}};
                carry_r <= 1'b0;
                valid_r <= 1'b0;
            end else if (advance_s) begin
                data_r  <= q_s;
                carry_r <= cq_s;
                valid_r <= v_s;
            end
        end

        if (k < SHW - 1) begin : g_ctl
            logic [SHW-1:0] shamt_r;
            logic [2:0]     mode_r;

            // Control fields travel with the operand to the later stages.
            always_ff @(posedge clk) begin
                if (rst) begin
                    shamt_r <= {SHW{1'b0}};
                    mode_r  <= 3'b000;
                end else if (advance_s) begin
                    shamt_r <= sh_s;
                    mode_r  <= m_s;
                end
            end
        end else begin : g_last
            // Zero flag is taken from the final data so it is registered alongside it.
            always_ff @(posedge clk) begin
                if (rst) begin
                    zero_r <= 1'b0;
                end else if (advance_s) begin
                    zero_r <= (q_s == {WIDTH{1'b0}});
                end
            end
        end
    end

    assign out_valid = g_stage[SHW-1].valid_r;
    assign out_data  = g_stage[SHW-1].data_r;
    assign out_carry = g_stage[SHW-1].carry_r;
    assign out_zero  = zero_r;

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Self-checking bench: directed vectors, backpressure and reset sequences on WIDTH=8,
// plus a random scoreboard regression on WIDTH=8 and WIDTH=32 instances.
module tb_pipelined_barrel_shifter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [1:0]  iv;
    logic [1:0]  ordy;
    logic [31:0] idat [2];
    logic [4:0]  ish  [2];
    logic [2:0]  imd  [2];

    logic        ir8, ov8, oc8, oz8, ir32, ov32, oc32, oz32;
    logic [7:0]  od8;
    logic [31:0] od32;
    logic [1:0]  ir, ov, oc, oz;
    logic [31:0] odat [2];

    assign ir = {ir32, ir8};
    assign ov = {ov32, ov8};
    assign oc = {oc32, oc8};
    assign oz = {oz32, oz8};
    assign odat[0] = {24'h000000, od8};
    assign odat[1] = od32;

    pipelined_barrel_shifter #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst),
        .in_valid(iv[0]), .in_ready(ir8), .in_data(idat[0][7:0]),
        .in_shamt(ish[0][2:0]), .in_mode(imd[0]),
        .out_valid(ov8), .out_ready(ordy[0]), .out_data(od8),
        .out_carry(oc8), .out_zero(oz8)
    );

    pipelined_barrel_shifter #(.WIDTH(32)) dut32 (
        .clk(clk), .rst(rst),
        .in_valid(iv[1]), .in_ready(ir32), .in_data(idat[1]),
        .in_shamt(ish[1]), .in_mode(imd[1]),
        .out_valid(ov32), .out_ready(ordy[1]), .out_data(od32),
        .out_carry(oc32), .out_zero(oz32)
    );

    int n_cmp = 0;
    int n_fail = 0;
    int acc [2];
    int got [2];
    logic [33:0] expq [2][$];
    bit mon_on = 1'b0;

    typedef struct {
        logic [7:0] d;
        logic [2:0] sh;
        logic [2:0] m;
        logic [7:0] ed;
        logic       ec;
        logic       ez;
    } vec_t;

    vec_t tbl [7];

    // Bit-by-bit reference: result bit i is picked straight from its source position.
    function automatic logic [33:0] ref_model(input int w, input logic [31:0] d,
                                              input int s, input logic [2:0] m);
        logic [31:0] r;
        logic        c;
        r = 32'h0;
        for (int i = 0; i < w; i++) begin
            case (m)
                3'd0:    r[i] = (i >= s) ? d[i-s] : 1'b0;
                3'd1:    r[i] = (i + s < w) ? d[i+s] : 1'b0;
                3'd2:    r[i] = (i + s < w) ? d[i+s] : d[w-1];
                3'd3:    r[i] = d[(i - s + w) % w];
                3'd4:    r[i] = d[(i + s) % w];
                default: r[i] = d[i];
            endcase
        end
        if (s == 0)                    c = 1'b0;
        else if (m == 3'd0)            c = d[w-s];
        else if (m == 3'd1 || m == 3'd2) c = d[s-1];
        else                           c = 1'b0;
        return {(r == 32'h0), c, r};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard: record accepts and compare drains, both sampled mid-cycle.
    always @(negedge clk) begin
        if (mon_on) begin
            for (int u = 0; u < 2; u++) begin
                int w;
                logic [33:0] e;
                w = (u == 0) ? 8 : 32;
                if (iv[u] && ir[u]) begin
                    expq[u].push_back(ref_model(w, idat[u], int'(ish[u]), imd[u]));
                    acc[u]++;
                end
                if (ov[u] && ordy[u]) begin
                    if (expq[u].size() == 0) begin
                        n_cmp++;
                        n_fail++;
                        $display("FAIL rand%0d_extra: got unexpected result %h expected none", w, odat[u]);
                    end else begin
                        e = expq[u].pop_front();
                        chk($sformatf("rand%0d_data", w), odat[u], e[31:0]);
                        chk($sformatf("rand%0d_carry", w), {31'h0, oc[u]}, {31'h0, e[32]});
                        chk($sformatf("rand%0d_zero", w), {31'h0, oz[u]}, {31'h0, e[33]});
                        got[u]++;
                    end
                end
            end
        end
    end

    // Single operand on the 8-bit instance with nominal-latency checks.
    task automatic apply_vec(input vec_t v);
        iv[0] = 1'b1;
        idat[0] = {24'h000000, v.d};
        ish[0] = {2'b00, v.sh};
        imd[0] = v.m;
        @(negedge clk);
        chk("vec_in_ready", {31'h0, ir[0]}, 32'd1);
        @(posedge clk); #1;
        iv[0] = 1'b0;
        @(negedge clk);
        chk("vec_lat1_valid", {31'h0, ov[0]}, 32'd0);
        @(posedge clk); @(negedge clk);
        chk("vec_lat2_valid", {31'h0, ov[0]}, 32'd0);
        @(posedge clk); @(negedge clk);
        chk("vec_valid", {31'h0, ov[0]}, 32'd1);
        chk("vec_data", odat[0], {24'h000000, v.ed});
        chk("vec_carry", {31'h0, oc[0]}, {31'h0, v.ec});
        chk("vec_zero", {31'h0, oz[0]}, {31'h0, v.ez});
        @(posedge clk); #1;
    endtask

    initial begin
        #1_000_000;
        n_fail++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $fatal(1);
    end

    initial begin
        logic [7:0]  bp_d  [4];
        logic [2:0]  bp_sh [4];
        logic [2:0]  bp_m  [4];
        logic [33:0] bp_e  [4];

        tbl[0] = '{8'hB5, 3'd3, 3'b000, 8'hA8, 1'b1, 1'b0};
        tbl[1] = '{8'h96, 3'd2, 3'b010, 8'hE5, 1'b1, 1'b0};
        tbl[2] = '{8'h0F, 3'd4, 3'b001, 8'h00, 1'b1, 1'b1};
        tbl[3] = '{8'h81, 3'd1, 3'b011, 8'h03, 1'b0, 1'b0};
        tbl[4] = '{8'h81, 3'd1, 3'b100, 8'hC0, 1'b0, 1'b0};
        tbl[5] = '{8'h5A, 3'd5, 3'b101, 8'h5A, 1'b0, 1'b0};
        tbl[6] = '{8'hFF, 3'd0, 3'b000, 8'hFF, 1'b0, 1'b0};

        rst = 1'b1;
        iv = 2'b00;
        ordy = 2'b11;
        for (int u = 0; u < 2; u++) begin
            idat[u] = 32'h0; ish[u] = 5'd0; imd[u] = 3'd0; acc[u] = 0; got[u] = 0;
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            chk("reset_valid", {31'h0, ov[u]}, 32'd0);
            chk("reset_data", odat[u], 32'd0);
            chk("reset_carry", {31'h0, oc[u]}, 32'd0);
            chk("reset_zero", {31'h0, oz[u]}, 32'd0);
            chk("reset_in_ready", {31'h0, ir[u]}, 32'd1);
        end
        @(posedge clk); #1;

        for (int i = 0; i < 7; i++) apply_vec(tbl[i]);

        // Backpressure: three accepts fill the pipe, the fourth waits behind a held result.
        for (int j = 0; j < 4; j++) begin
            bp_d[j] = 8'($urandom);
            bp_sh[j] = 3'($urandom_range(0, 7));
            bp_m[j] = 3'($urandom_range(0, 7));
            bp_e[j] = ref_model(8, {24'h0, bp_d[j]}, int'(bp_sh[j]), bp_m[j]);
        end
        ordy[0] = 1'b0;
        for (int j = 0; j < 3; j++) begin
            iv[0] = 1'b1; idat[0] = {24'h0, bp_d[j]}; ish[0] = {2'b00, bp_sh[j]}; imd[0] = bp_m[j];
            @(negedge clk);
            chk("bp_fill_ready", {31'h0, ir[0]}, 32'd1);
            @(posedge clk); #1;
        end
        idat[0] = {24'h0, bp_d[3]}; ish[0] = {2'b00, bp_sh[3]}; imd[0] = bp_m[3];
        repeat (5) begin
            @(negedge clk);
            chk("bp_hold_ready", {31'h0, ir[0]}, 32'd0);
            chk("bp_hold_valid", {31'h0, ov[0]}, 32'd1);
            chk("bp_hold_data", odat[0], bp_e[0][31:0]);
            chk("bp_hold_carry", {31'h0, oc[0]}, {31'h0, bp_e[0][32]});
            @(posedge clk); #1;
        end
        ordy[0] = 1'b1;
        @(negedge clk);
        chk("bp_release_ready", {31'h0, ir[0]}, 32'd1);
        chk("bp_out0_data", odat[0], bp_e[0][31:0]);
        @(posedge clk); #1;
        iv[0] = 1'b0;
        for (int j = 1; j < 4; j++) begin
            @(negedge clk);
            chk("bp_out_valid", {31'h0, ov[0]}, 32'd1);
            chk("bp_out_data", odat[0], bp_e[j][31:0]);
            chk("bp_out_carry", {31'h0, oc[0]}, {31'h0, bp_e[j][32]});
            chk("bp_out_zero", {31'h0, oz[0]}, {31'h0, bp_e[j][33]});
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("bp_no_dup", {31'h0, ov[0]}, 32'd0);
        @(posedge clk); #1;

        // Reset with a full pipe and an operand offered in the reset cycle.
        for (int j = 0; j < 3; j++) begin
            iv[0] = 1'b1; idat[0] = {24'h0, tbl[j].d}; ish[0] = {2'b00, tbl[j].sh}; imd[0] = tbl[j].m;
            @(posedge clk); #1;
        end
        rst = 1'b1;
        idat[0] = 32'h000000FF; ish[0] = 5'd1; imd[0] = 3'd1;
        @(posedge clk); #1;
        rst = 1'b0;
        iv[0] = 1'b0;
        @(negedge clk);
        chk("rst_mid_valid", {31'h0, ov[0]}, 32'd0);
        chk("rst_mid_data", odat[0], 32'd0);
        chk("rst_mid_carry", {31'h0, oc[0]}, 32'd0);
        chk("rst_mid_zero", {31'h0, oz[0]}, 32'd0);
        repeat (3) begin
            @(posedge clk); @(negedge clk);
            chk("rst_mid_flushed", {31'h0, ov[0]}, 32'd0);
        end
        @(posedge clk); #1;
        apply_vec(tbl[0]);

        // Random regression on both widths with random consumer backpressure.
        mon_on = 1'b1;
        for (int cyc = 0; cyc < 20000 && (acc[0] < 1000 || acc[1] < 1000); cyc++) begin
            for (int u = 0; u < 2; u++) begin
                int w;
                w = (u == 0) ? 8 : 32;
                iv[u] = (acc[u] < 1000) && ($urandom_range(0, 3) != 0);
                idat[u] = (u == 0) ? {24'h0, 8'($urandom)} : $urandom;
                ish[u] = 5'($urandom_range(0, w - 1));
                imd[u] = 3'($urandom_range(0, 7));
                ordy[u] = ($urandom_range(0, 3) != 0);
            end
            @(posedge clk); #1;
        end
        iv = 2'b00;
        ordy = 2'b11;
        for (int t = 0; t < 100 && (expq[0].size() != 0 || expq[1].size() != 0); t++)
            @(negedge clk);
        @(posedge clk); #1;
        mon_on = 1'b0;
        chk("rand8_count", got[0], 32'd1000);
        chk("rand32_count", got[1], 32'd1000);
        chk("rand8_pending", expq[0].size(), 32'd0);
        chk("rand32_pending", expq[1].size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
